// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data-memory bus between the memory-access stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );
  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage doing loads/stores over a req/ack bus and registering MEM/WB outputs.
// Define MEMSTAGE_TIMEOUT_EN to enable the WAIT watchdog that aborts after TIMEOUT cycles without ack.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               alu_result_i,
  input  logic [31:0]               store_data_i,
  input  logic [3:0]                wr_dest_i,
  input  logic                      wmem_i,
  input  logic                      rmem_i,
  input  logic                      wreg_i,
  input  logic                      jmp_i,
  output logic                      stall_o,
  mem_access_stage_if.master        dmem,
  output logic [31:0]               wb_data_o,
  output logic [3:0]                wb_dest_o,
  output logic                      wb_wreg_o,
  output logic                      wb_jmp_o,
  output logic                      err_o
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  dest_q, dest_d;
  logic        wreg_q, wreg_d, jmp_q, jmp_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [3:0]  wb_dest_q, wb_dest_d;
  logic        wb_wreg_q, wb_wreg_d, wb_jmp_q, wb_jmp_d;
  logic        err_q, err_d;
  logic        stall_c, mem_op, illegal, tmo;
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_access_stage: TIMEOUT must be at least 2");
  end
  assign mem_op  = rmem_i | wmem_i;
  assign illegal = (rmem_i & wmem_i) | (mem_op & (alu_result_i[1:0] != 2'b00));
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dest_d    = dest_q;
    wreg_d    = wreg_q;
    jmp_d     = jmp_q;
    wb_data_d = wb_data_q;
    wb_dest_d = wb_dest_q;
    wb_wreg_d = wb_wreg_q;
    wb_jmp_d  = wb_jmp_q;
    err_d     = 1'b0;
    stall_c   = 1'b0;
    if (state_q == IDLE) begin
      if (!mem_op) begin
        wb_data_d = alu_result_i;
        wb_dest_d = wr_dest_i;
        wb_wreg_d = wreg_i;
        wb_jmp_d  = jmp_i;
      end else if (illegal) begin
        err_d     = 1'b1;
        wb_data_d = '0;
        wb_dest_d = wr_dest_i;
        wb_wreg_d = 1'b0;
        wb_jmp_d  = 1'b0;
      end else begin
        stall_c   = 1'b1;
        state_d   = WAIT;
        req_d     = 1'b1;
        we_d      = wmem_i;
        addr_d    = alu_result_i;
        wdata_d   = store_data_i;
        dest_d    = wr_dest_i;
        wreg_d    = wreg_i;
        jmp_d     = jmp_i;
        wb_wreg_d = 1'b0;
        wb_jmp_d  = 1'b0;
      end
    end else if (dmem.dmem_ack_i) begin
      state_d   = IDLE;
      req_d     = 1'b0;
      wb_data_d = we_q ? addr_q : dmem.dmem_rdata_i;
      wb_dest_d = dest_q;
      wb_wreg_d = wreg_q & ~we_q;
      wb_jmp_d  = jmp_q;
    end else if (tmo) begin
      state_d   = IDLE;
      req_d     = 1'b0;
      err_d     = 1'b1;
      wb_data_d = '0;
      wb_wreg_d = 1'b0;
      wb_jmp_d  = 1'b0;
    end else begin
      stall_c = 1'b1;
    end
  end
`ifdef MEMSTAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q;
  assign tmo = cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= (state_q == WAIT && state_d == WAIT) ? cnt_q + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dest_q    <= '0;
      wreg_q    <= 1'b0;
      jmp_q     <= 1'b0;
      wb_data_q <= '0;
      wb_dest_q <= '0;
      wb_wreg_q <= 1'b0;
      wb_jmp_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dest_q    <= dest_d;
      wreg_q    <= wreg_d;
      jmp_q     <= jmp_d;
      wb_data_q <= wb_data_d;
      wb_dest_q <= wb_dest_d;
      wb_wreg_q <= wb_wreg_d;
      wb_jmp_q  <= wb_jmp_d;
      err_q     <= err_d;
    end
  end
  // stall is forced low during reset so an aborted access never holds the pipeline
  assign stall_o           = stall_c & ~rst;
  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign wb_data_o         = wb_data_q;
  assign wb_dest_o         = wb_dest_q;
  assign wb_wreg_o         = wb_wreg_q;
  assign wb_jmp_o          = wb_jmp_q;
  assign err_o             = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and random ops checked against a transaction-level model of the MEM stage.
module tb_mem_access_stage;
  localparam int TO = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] alu_result_i, store_data_i;
  logic [3:0]  wr_dest_i;
  logic        wmem_i, rmem_i, wreg_i, jmp_i;
  logic        stall_o, wb_wreg_o, wb_jmp_o, err_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_dest_o;
  int          checks = 0, errors = 0;
  mem_access_stage_if dmem ();
  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .wr_dest_i(wr_dest_i), .wmem_i(wmem_i), .rmem_i(rmem_i), .wreg_i(wreg_i), .jmp_i(jmp_i),
    .stall_o(stall_o), .dmem(dmem), .wb_data_o(wb_data_o), .wb_dest_o(wb_dest_o),
    .wb_wreg_o(wb_wreg_o), .wb_jmp_o(wb_jmp_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  typedef enum int {K_ALU, K_LOAD, K_STORE, K_BOTH} kind_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        wreg, jmp, err, access;
  } wb_t;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // what write-back must show once the instruction retires
  function automatic wb_t model(kind_t k, logic [31:0] a, logic [31:0] rd, logic [3:0] d, logic w, logic j);
    wb_t r;
    bit bad = (k == K_BOTH) || (k != K_ALU && a[1:0] != 2'b00);
    r.dest = d;
    r.err = 1'b0;
    r.access = 1'b0;
    if (k == K_ALU) begin
      r.data = a; r.wreg = w; r.jmp = j;
    end else if (bad) begin
      r.data = 0; r.wreg = 1'b0; r.jmp = 1'b0; r.err = 1'b1;
    end else begin
      r.access = 1'b1;
      r.data = (k == K_LOAD) ? rd : a;
      r.wreg = (k == K_LOAD) ? w : 1'b0;
      r.jmp = j;
    end
    return r;
  endfunction
  task automatic run_op(kind_t k, logic [31:0] a, logic [31:0] sd, logic [31:0] rd,
                        logic [3:0] d, logic w, logic j, int lat);
    wb_t e;
    int stalls = 0, waits = 0;
    bit done = 0, acked;
    e = model(k, a, rd, d, w, j);
    wmem_i = (k == K_STORE || k == K_BOTH);
    rmem_i = (k == K_LOAD || k == K_BOTH);
    alu_result_i = a; store_data_i = sd; wr_dest_i = d; wreg_i = w; jmp_i = j;
    if (!e.access) begin
      #1 check("stall_no_access", stall_o, 0);
      @(negedge clk);
      check("req_no_access", dmem.dmem_req_o, 0);
      check("err", err_o, e.err);
      check("wb_data", wb_data_o, e.data);
      check("wb_wreg", wb_wreg_o, e.wreg);
      check("wb_jmp", wb_jmp_o, e.jmp);
      if (!e.err) check("wb_dest", wb_dest_o, e.dest);
    end else begin
      for (int c = 0; c < 50 && !done; c++) begin
        acked = 0;
        if (dmem.dmem_req_o) begin
          check("addr", dmem.dmem_addr_o, a);
          check("we", dmem.dmem_we_o, k == K_STORE);
          if (k == K_STORE) check("wdata", dmem.dmem_wdata_o, sd);
          if (waits == lat) begin
            dmem.dmem_ack_i = 1'b1; dmem.dmem_rdata_i = rd; acked = 1;
          end
          waits++;
        end
        #1 if (stall_o) stalls++;
        @(negedge clk);
        dmem.dmem_ack_i = 1'b0; dmem.dmem_rdata_i = $urandom;
        if (acked) done = 1;
        else check("wb_wreg_wait", wb_wreg_o, 0);
      end
      check("ack_seen", done, 1);
      check("stall_cycles", stalls, lat + 1);
      check("req_dropped", dmem.dmem_req_o, 0);
      check("err_access", err_o, 0);
      check("wb_data", wb_data_o, e.data);
      check("wb_dest", wb_dest_o, e.dest);
      check("wb_wreg", wb_wreg_o, e.wreg);
      check("wb_jmp", wb_jmp_o, e.jmp);
    end
  endtask
  initial begin
    int cnt_a, cnt_b;
    kind_t k;
    logic [31:0] a;
    {alu_result_i, store_data_i, wr_dest_i, wmem_i, rmem_i, wreg_i, jmp_i} = '0;
    dmem.dmem_ack_i = 1'b0; dmem.dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    check("rst_req", dmem.dmem_req_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_wb_wreg", wb_wreg_o, 0);
    check("rst_err", err_o, 0);
    rst = 1'b0;
    run_op(K_ALU, 32'h1234, 0, 0, 4'd3, 1, 0, 0);
    run_op(K_LOAD, 32'h40, 0, 32'hDEAD_BEEF, 4'd5, 1, 0, 2);
    run_op(K_STORE, 32'h100, 32'hCAFE, 32'h1111_2222, 4'd6, 1, 1, 0);
    run_op(K_LOAD, 32'h42, 0, 0, 4'd2, 1, 1, 0);
    run_op(K_BOTH, 32'h80, 0, 0, 4'd2, 1, 1, 0);
    dmem.dmem_ack_i = 1'b1;
    run_op(K_ALU, 32'h5555_AAAA, 0, 0, 4'd9, 1, 1, 0);
    dmem.dmem_ack_i = 1'b0;
    run_op(K_LOAD, 32'h200, 0, 32'h0BAD_F00D, 4'd1, 1, 1, 1);
    run_op(K_LOAD, 32'h204, 0, 32'h1357_9BDF, 4'd4, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      k = kind_t'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      run_op(k, a, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, TO - 1));
    end
    rmem_i = 1'b1; wmem_i = 1'b0; alu_result_i = 32'h80; wr_dest_i = 4'd8; wreg_i = 1'b1; jmp_i = 1'b0;
    @(negedge clk);
`ifdef MEMSTAGE_TIMEOUT_EN
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 20; c++) begin
      if (err_o) break;
      if (dmem.dmem_req_o) cnt_a++;
      #1 if (stall_o) cnt_b++;
      @(negedge clk);
    end
    rmem_i = 1'b0; wreg_i = 1'b0;
    check("tmo_req_cycles", cnt_a, TO);
    check("tmo_wait_stalls", cnt_b, TO - 1);
    check("tmo_err", err_o, 1);
    check("tmo_req_drop", dmem.dmem_req_o, 0);
    check("tmo_wb_wreg", wb_wreg_o, 0);
    check("tmo_wb_data", wb_data_o, 0);
    @(negedge clk);
    check("tmo_err_pulse", err_o, 0);
`else
    cnt_a = 0;
    for (int c = 0; c < 100; c++) begin
      #1 if (stall_o) cnt_a++;
      @(negedge clk);
    end
    check("hold_stall_cycles", cnt_a, 100);
    check("hold_req", dmem.dmem_req_o, 1);
    dmem.dmem_ack_i = 1'b1; dmem.dmem_rdata_i = 32'h0000_0005;
    #1 check("hold_ack_stall", stall_o, 0);
    @(negedge clk);
    dmem.dmem_ack_i = 1'b0; rmem_i = 1'b0; wreg_i = 1'b0;
    check("hold_wb_data", wb_data_o, 5);
    check("hold_wb_wreg", wb_wreg_o, 1);
    check("hold_err", err_o, 0);
`endif
    rmem_i = 1'b1; alu_result_i = 32'h44; wr_dest_i = 4'd7; wreg_i = 1'b1; jmp_i = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_req", dmem.dmem_req_o, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_req", dmem.dmem_req_o, 0);
    check("rst_mid_stall", stall_o, 0);
    check("rst_mid_wb_data", wb_data_o, 0);
    check("rst_mid_wb_dest", wb_dest_o, 0);
    check("rst_mid_wb_wreg", wb_wreg_o, 0);
    check("rst_mid_wb_jmp", wb_jmp_o, 0);
    {alu_result_i, store_data_i, wr_dest_i, wmem_i, rmem_i, wreg_i, jmp_i} = '0;
    @(negedge clk);
    rst = 1'b0;
    dmem.dmem_ack_i = 1'b1; dmem.dmem_rdata_i = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_req", dmem.dmem_req_o, 0);
      check("post_rst_wb_wreg", wb_wreg_o, 0);
      check("post_rst_wb_data", wb_data_o, 0);
    end
    dmem.dmem_ack_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

- Memory-access stage of the CPU pipeline; sits directly downstream of the EX/MEM pipeline register and upstream of write-back.
- Consumes the registered ALU result, destination and control bits, and performs loads/stores against a variable-latency data memory through a req/ack handshake.
- Stalls the upstream register while an access is outstanding.
- Registers the result into the MEM/WB outputs.

## Interface
Parameters:
- TIMEOUT, 16: max cycles waited for dmem_ack_i before aborting (≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- alu_result_i  in  32  address for mem ops; write-back data otherwise.
- store_data_i  in  32  store data.
- wr_dest_i  in  4  destination register.
- wmem_i, rmem_i, wreg_i, jmp_i  in  1 each  store, load, register write, jump.
- stall_o  out  1  combinational; upstream register holds while high.
- dmem_req_o, dmem_we_o  out  1  registered request / write enable.
- dmem_addr_o, dmem_wdata_o  out  32  registered address / store data.
- dmem_ack_i  in  1  access complete; dmem_rdata_i valid this cycle for loads.
- dmem_rdata_i  in  32  load data.
- wb_data_o  out  32  write-back data.
- wb_dest_o  out  4  write-back destination.
- wb_wreg_o, wb_jmp_o  out  1  write-back register write / jump flags.
- err_o  out  1  one-cycle pulse on an aborted op.

## Operation
- States: IDLE and WAIT.
- Mem op = rmem_i | wmem_i.
- IDLE, no mem op:
  - wb_* loaded with inputs at the next edge: wb_data_o = alu_result_i, wb_dest_o = wr_dest_i, wb_wreg_o = wreg_i, wb_jmp_o = jmp_i.
- IDLE, illegal op: rmem_i & wmem_i both high, or alu_result_i[1:0] ≠ 0.
  - No memory access.
  - Next edge: err_o=1 and a bubble is written (wb_wreg_o=0, wb_jmp_o=0, wb_data_o=0).
  - stall_o=0.
- IDLE, legal mem op:
  - stall_o=1.
  - Next edge: latch addr/wdata/we/dest/wreg/jmp, set dmem_req_o=1 → WAIT, counter=0.
  - wb_wreg_o=0 while waiting (bubble).
- WAIT, dmem_ack_i=1:
  - stall_o=0.
  - Next edge: dmem_req_o=0 → IDLE.
  - wb_data_o = dmem_rdata_i for loads; store address for stores.
  - wb_wreg_o = latched wreg & load.
  - wb_dest_o and wb_jmp_o from latched values.
- WAIT, no ack: stall_o=1, counter increments.
- Timeout (macro enabled): counter reaches TIMEOUT-1 without ack.
  - stall_o=0 that cycle.
  - Next edge: dmem_req_o=0, err_o=1, bubble written → IDLE.
- dmem_addr_o, dmem_wdata_o and dmem_we_o are stable for the whole time dmem_req_o=1.
- Reset mid-access: the request is dropped immediately and no write-back occurs.

## Timing
- All outputs reset to 0; state resets to IDLE; counter resets to 0.
- Non-mem op: wb_* valid 1 cycle after the inputs are presented.
- Mem op with ack N cycles after req rises (N≥0, ack in first WAIT cycle = N=0):
  - stall_o high for N+1 cycles.
  - Result on wb_* at edge N+2 after presentation.
- Back-to-back mem ops: 1 IDLE cycle between requests; dmem_req_o drops for ≥1 cycle.
- dmem_ack_i is ignored in IDLE.

## Configuration
- MEMSTAGE_TIMEOUT_EN defined:
  - WAIT watchdog active as above; counter width is clog2(TIMEOUT).
- MEMSTAGE_TIMEOUT_EN not defined:
  - No counter; WAIT holds indefinitely until ack.
  - err_o asserts only for illegal ops.

## Test plan
- ALU passthrough:
  - Stimulus: alu_result_i=0x0000_1234, wr_dest_i=3, wreg_i=1, no mem op.
  - Next cycle: wb_data_o=0x1234, wb_dest_o=3, wb_wreg_o=1; stall_o never high.
- Load with 3-cycle memory latency:
  - Stimulus: rmem_i=1, alu_result_i=0x40, dest 5; ack on the 3rd WAIT cycle with rdata=0xDEAD_BEEF.
  - Required: stall_o high 3 cycles; dmem_addr_o=0x40 and dmem_we_o=0 throughout.
  - Result: wb_data_o=0xDEADBEEF, wb_dest_o=5, wb_wreg_o=1.
- Store with immediate ack:
  - Stimulus: wmem_i=1, addr 0x100, store_data_i=0xCAFE; ack in first WAIT cycle.
  - Required: dmem_we_o=1, dmem_wdata_o=0xCAFE; stall_o high 1 cycle; wb_wreg_o=0.
- Illegal ops:
  - Misaligned load at 0x42: no dmem_req_o, err_o one pulse, wb_wreg_o=0.
  - rmem_i=wmem_i=1: same response.
- Timeout (MEMSTAGE_TIMEOUT_EN, TIMEOUT=4):
  - Stimulus: load, ack never asserted.
  - Required: req high 4 cycles then drops; err_o pulses; state returns to IDLE.
  - Without the macro: stall_o stays high for 100 cycles.
- Reset mid-WAIT:
  - Stimulus: assert rst 2 cycles into WAIT.
  - Required: dmem_req_o, stall_o and all wb_* go to 0 immediately; no write-back occurs after release.
